// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score update producer
// Contents: FSM state enum, default point values, point/emission widths,
//           mothership bonus lookup.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_PTS_TOP = 30;
  localparam int DEF_PTS_MID = 20;
  localparam int DEF_PTS_LOW = 10;
  localparam int DEF_ACC_W   = 12;
  localparam int SCORE_UPD_W = 8;
  // Largest single-cycle sum is 300 + 2*PTS_TOP, which fits in 10 bits.
  localparam int PTS_W       = 10;

  function automatic logic [PTS_W-1:0] ship_points(input logic [1:0] sel);
    logic [PTS_W-1:0] pts;
    case (sel)
      2'd0: pts = 10'd50;
      2'd1: pts = 10'd100;
      2'd2: pts = 10'd150;
      2'd3: pts = 10'd300;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/score_points_lut.sv
// rtl/score_points_lut.sv - combinational hit-to-points lookup for one cycle
// Ports:
//   alien_hit_i    alien destroyed this cycle
//   alien_row_i    row of the destroyed alien
//   ship_hit_i     mothership destroyed this cycle
//   ship_bonus_i   mothership value select
//   combo_i        double alien points (mothership never doubled)
//   points_o       total points earned this cycle
module score_points_lut
  import score_pkg::*;
#(
  parameter int PTS_TOP = DEF_PTS_TOP,
  parameter int PTS_MID = DEF_PTS_MID,
  parameter int PTS_LOW = DEF_PTS_LOW
) (
  input  logic             alien_hit_i,
  input  logic [2:0]       alien_row_i,
  input  logic             ship_hit_i,
  input  logic [1:0]       ship_bonus_i,
  input  logic             combo_i,
  output logic [PTS_W-1:0] points_o
);

  logic [PTS_W-1:0] alien_pts;
  logic [PTS_W-1:0] ship_pts;

  always_comb begin
    alien_pts = '0;
    if (alien_hit_i) begin
      case (alien_row_i)
        3'd0:       alien_pts = PTS_W'(PTS_TOP);
        3'd1, 3'd2: alien_pts = PTS_W'(PTS_MID);
        default:    alien_pts = PTS_W'(PTS_LOW);
      endcase
      if (combo_i) alien_pts = alien_pts << 1;
    end
    ship_pts = ship_hit_i ? ship_points(ship_bonus_i) : '0;
    points_o = alien_pts + ship_pts;
  end

endmodule

// File: rtl/score_update_gen.sv
// rtl/score_update_gen.sv - turns hit events into once-per-frame score increments
// Optional feature: SCORE_COMBO_EN enables frame-combo doubling of alien points.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   startOfFrame   one-cycle frame pulse; emission edge
//   startGame      clears everything and starts accepting hits
//   gameOver       stop accepting hits and drain what is pending
//   alienHit/alienRow, shipHit/shipBonus   hit events
//   scoreUpdate    points for this frame, held for the whole frame
//   busy           points still pending or being presented
//   accOverflow    sticky: accumulator saturated
//   comboActive    alien doubling in effect
module score_update_gen
  import score_pkg::*;
#(
  parameter int PTS_TOP = DEF_PTS_TOP,
  parameter int PTS_MID = DEF_PTS_MID,
  parameter int PTS_LOW = DEF_PTS_LOW,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic                   startGame,
  input  logic                   gameOver,
  input  logic                   alienHit,
  input  logic [2:0]             alienRow,
  input  logic                   shipHit,
  input  logic [1:0]             shipBonus,
  output logic [SCORE_UPD_W-1:0] scoreUpdate,
  output logic                   busy,
  output logic                   accOverflow,
  output logic                   comboActive
);

  localparam int MAX_EMIT = (1 << SCORE_UPD_W) - 1;

  state_e                 state_q, state_d;
  logic [ACC_W-1:0]       pending_q, pending_d;
  logic [SCORE_UPD_W-1:0] score_q, score_d;
  logic                   ovf_q, ovf_d;

  logic [PTS_W-1:0]       pts;
  logic [PTS_W-1:0]       add;
  logic [ACC_W-1:0]       emit;
  logic [ACC_W-1:0]       base;
  logic [ACC_W:0]         sum;
  logic                   combo_on;

  score_points_lut #(
    .PTS_TOP (PTS_TOP),
    .PTS_MID (PTS_MID),
    .PTS_LOW (PTS_LOW)
  ) u_lut (
    .alien_hit_i  (alienHit),
    .alien_row_i  (alienRow),
    .ship_hit_i   (shipHit),
    .ship_bonus_i (shipBonus),
    .combo_i      (combo_on),
    .points_o     (pts)
  );

`ifdef SCORE_COMBO_EN
  logic [1:0] combo_q, combo_d;
  logic       frame_hit_q, frame_hit_d;
  logic       alien_taken;

  // The SOF-cycle hit belongs to the frame that starts at this edge.
  always_comb begin
    alien_taken = alienHit && (state_q == RUN);
    combo_d     = combo_q;
    frame_hit_d = frame_hit_q | alien_taken;
    if (startOfFrame) begin
      combo_d     = frame_hit_q ? ((combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1) : 2'd0;
      frame_hit_d = alien_taken;
    end
    if (startGame) begin
      combo_d     = '0;
      frame_hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      combo_q     <= '0;
      frame_hit_q <= 1'b0;
    end else begin
      combo_q     <= combo_d;
      frame_hit_q <= frame_hit_d;
    end
  end

  assign combo_on = (combo_q == 2'd3);
`else
  assign combo_on = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    score_d   = score_q;
    ovf_d     = ovf_q;

    emit = (pending_q > ACC_W'(MAX_EMIT)) ? ACC_W'(MAX_EMIT) : pending_q;
    // Subtract the emitted amount first so same-cycle hits land in the next frame.
    base = startOfFrame ? (pending_q - emit) : pending_q;
    add  = (state_q == RUN) ? pts : '0;
    sum  = {1'b0, base} + (ACC_W+1)'(add);

    if (sum[ACC_W]) begin
      pending_d = '1;
      ovf_d     = 1'b1;
    end else begin
      pending_d = sum[ACC_W-1:0];
    end

    if (startOfFrame) score_d = (state_q == IDLE) ? '0 : emit[SCORE_UPD_W-1:0];

    case (state_q)
      IDLE:    state_d = IDLE;
      RUN:     if (gameOver) state_d = DRAIN;
      DRAIN:   if (startOfFrame && (pending_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (startGame) begin
      state_d   = RUN;
      pending_d = '0;
      score_d   = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      score_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      score_q   <= score_d;
      ovf_q     <= ovf_d;
    end
  end

  assign scoreUpdate = score_q;
  assign busy        = (pending_q != '0) || (score_q != '0);
  assign accOverflow = ovf_q;
  assign comboActive = combo_on;

endmodule
